// File: rtl/branch_pht.sv
// Branch direction predictor: PHT of 2-bit saturating counters, bimodal or gshare indexed.
// Latency: prediction is combinational (0 cycles); updates land at the clock edge ending the upd_valid cycle.
// Backpressure: none; one prediction and one update are accepted every cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pred_pc             PC of the instruction in IF
//   pred_taken/pred_idx predicted direction and the PHT index used (carried down the pipe)
//   upd_valid/upd_idx   one resolved-branch update per pulse, at the index carried from IF
//   upd_taken           actual outcome
//   upd_mispred         EX saw a wrong prediction (qualified by upd_valid)
//   perf_br_cnt         resolved branches, wraps
//   perf_mispred_cnt    mispredictions, wraps
module branch_pht #(
  parameter int         ENTRIES = 64,
  parameter int         IDX_W   = 6,
  parameter int         HIST_W  = 0,
  parameter logic [1:0] INIT    = 2'b11,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
);

  logic [1:0]       pht [ENTRIES];
  logic [IDX_W-1:0] hist_ext;

  // PC bits outside the index field do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  // Global history, zero-extended into the low index bits. Bimodal mode has no GHR.
  generate
    if (HIST_W == 0) begin : g_bimodal
      assign hist_ext = '0;
    end else begin : g_gshare
      logic [HIST_W-1:0] ghr;

      // Non-speculative: shifts only on resolution, never at prediction time.
      if (HIST_W == 1) begin : g_h1
        always_ff @(posedge clk) begin
          if (rst)            ghr <= '0;
          else if (upd_valid) ghr <= upd_taken;
        end
      end else begin : g_hn
        always_ff @(posedge clk) begin
          if (rst)            ghr <= '0;
          else if (upd_valid) ghr <= {ghr[HIST_W-2:0], upd_taken};
        end
      end

      assign hist_ext = IDX_W'(ghr);
    end
  endgenerate

  // Prediction reads the registered table, so a same-cycle update to the same
  // entry is not bypassed: IF sees the pre-update counter.
  assign pred_idx   = pred_pc[IDX_W+1:2] ^ hist_ext;
  assign pred_taken = pht[pred_idx][1];

  // Update uses the index carried with the instruction, never a recomputed one,
  // so history movement between predict and resolve cannot misdirect the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= INIT;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (pht[upd_idx] != 2'b11) pht[upd_idx] <= pht[upd_idx] + 2'd1;
      end else begin
        if (pht[upd_idx] != 2'b00) pht[upd_idx] <= pht[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt      <= '0;
      perf_mispred_cnt <= '0;
    end else if (upd_valid) begin
      perf_br_cnt <= perf_br_cnt + CNT_W'(1);
      if (upd_mispred) perf_mispred_cnt <= perf_mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht: a bimodal instance (CNT_W=4) and a gshare instance (HIST_W=4)
// driven with identical stimulus and compared against a table-level reference model.
// Directed steps from the test plan are followed by a randomized run.
module tb_branch_pht;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispred;

  logic        pred_taken_a, pred_taken_b;
  logic [5:0]  pred_idx_a, pred_idx_b;
  logic [3:0]  perf_br_a, perf_mis_a;
  logic [31:0] perf_br_b, perf_mis_b;

  branch_pht #(.ENTRIES(64), .IDX_W(6), .HIST_W(0), .INIT(2'b11), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .pred_pc(pred_pc),
    .pred_taken(pred_taken_a), .pred_idx(pred_idx_a),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .perf_br_cnt(perf_br_a), .perf_mispred_cnt(perf_mis_a)
  );

  branch_pht #(.ENTRIES(64), .IDX_W(6), .HIST_W(4), .INIT(2'b11), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .pred_pc(pred_pc),
    .pred_taken(pred_taken_b), .pred_idx(pred_idx_b),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .perf_br_cnt(perf_br_b), .perf_mispred_cnt(perf_mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: counters as integers in 0..3, history as an integer mod 16.
  int          m_pht [64];
  int          m_ghr;
  logic [31:0] m_br, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 3;
    m_ghr = 0;
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic model_update(input logic t, input logic m, input logic [5:0] ui);
    if (t) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
    else   m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
    m_ghr = ((m_ghr * 2) + int'(t)) % 16;
    m_br  = m_br + 1;
    if (m) m_mis = m_mis + 1;
  endtask

  task automatic check_all();
    int ia, ib;
    ia = int'(pred_pc / 4) % 64;
    ib = ia ^ m_ghr;
    chk("idx_a",  32'(pred_idx_a),   32'(ia));
    chk("tk_a",   32'(pred_taken_a), 32'(m_pht[ia] >= 2));
    chk("idx_b",  32'(pred_idx_b),   32'(ib));
    chk("tk_b",   32'(pred_taken_b), 32'(m_pht[ib] >= 2));
    chk("br_a",   32'(perf_br_a),    m_br % 16);
    chk("mis_a",  32'(perf_mis_a),   m_mis % 16);
    chk("br_b",   perf_br_b,         m_br);
    chk("mis_b",  perf_mis_b,        m_mis);
  endtask

  // One cycle: drive just after a rising edge, check pre-update outputs at the
  // falling edge, then advance the model with the rising edge.
  task automatic step(input logic v, input logic [5:0] ui, input logic t, input logic m,
                      input logic [31:0] pc);
    upd_valid   = v;
    upd_idx     = ui;
    upd_taken   = t;
    upd_mispred = m;
    pred_pc     = pc;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (v) model_update(t, m, ui);
    #1;
  endtask

  // Reset with a live-looking update on the bus, which must be ignored.
  task automatic do_reset();
    rst         = 1'b1;
    upd_valid   = 1'b1;
    upd_idx     = 6'd5;
    upd_taken   = 1'b0;
    upd_mispred = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst       = 1'b0;
    upd_valid = 1'b0;
  endtask

  // Settle a new PC after an edge for an explicit constant check.
  task automatic look(input logic [31:0] pc);
    upd_valid = 1'b0;
    pred_pc   = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; pred_pc = 32'h0; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset state and default prediction.
    look(32'h1000);
    chk("rst_tk_a",  32'(pred_taken_a), 32'd1);
    chk("rst_idx_a", 32'(pred_idx_a),   32'd0);
    chk("rst_idx_b", 32'(pred_idx_b),   32'd0);
    chk("rst_br_b",  perf_br_b,         32'd0);
    chk("rst_mis_b", perf_mis_b,        32'd0);
    step(1'b0, 6'd0, 1'b0, 1'b0, 32'h1000);

    // Hysteresis on idx 5: 11 -> 10 -> 01, then taken back to 10.
    step(1'b1, 6'd5, 1'b0, 1'b0, 32'h14);
    look(32'h14); chk("hyst_10", 32'(pred_taken_a), 32'd1);
    step(1'b1, 6'd5, 1'b0, 1'b0, 32'h14);
    look(32'h14); chk("hyst_01", 32'(pred_taken_a), 32'd0);
    step(1'b1, 6'd5, 1'b1, 1'b0, 32'h14);
    look(32'h14); chk("hyst_back", 32'(pred_taken_a), 32'd1);

    // Saturation at 00 and recovery without wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 6'd5, 1'b0, 1'b0, 32'h14);
    look(32'h14); chk("sat_00", 32'(pred_taken_a), 32'd0);
    step(1'b1, 6'd5, 1'b1, 1'b0, 32'h14);
    look(32'h14); chk("sat_01", 32'(pred_taken_a), 32'd0);
    step(1'b1, 6'd5, 1'b1, 1'b0, 32'h14);
    look(32'h14); chk("sat_10", 32'(pred_taken_a), 32'd1);

    // Same-cycle conflict: counter at 10, not-taken update on the predicted entry.
    upd_valid = 1'b1; upd_idx = 6'd5; upd_taken = 1'b0; upd_mispred = 1'b0; pred_pc = 32'h14;
    #1; chk("conflict_now", 32'(pred_taken_a), 32'd1);
    step(1'b1, 6'd5, 1'b0, 1'b0, 32'h14);
    look(32'h14); chk("conflict_next", 32'(pred_taken_a), 32'd0);

    // Saturation at 11 stays 11 (idx 7 starts at INIT).
    step(1'b1, 6'd7, 1'b1, 1'b0, 32'h1C);
    step(1'b1, 6'd7, 1'b0, 1'b0, 32'h1C);
    look(32'h1C); chk("sat_11", 32'(pred_taken_a), 32'd1);

    // Gshare history 1,0,1,1 -> 4'b1011; pc 0x40 indexes 16 ^ 11.
    do_reset();
    step(1'b1, 6'd40, 1'b1, 1'b0, 32'h200);
    step(1'b1, 6'd40, 1'b0, 1'b0, 32'h200);
    step(1'b1, 6'd40, 1'b1, 1'b0, 32'h200);
    step(1'b1, 6'd40, 1'b1, 1'b0, 32'h200);
    look(32'h40);
    chk("gs_idx_b", 32'(pred_idx_b), 32'd27);
    chk("gs_idx_a", 32'(pred_idx_a), 32'd16);
    step(1'b1, 6'd40, 1'b0, 1'b0, 32'h40);
    do_reset();
    look(32'h40);
    chk("gs_rst_idx_b", 32'(pred_idx_b), 32'd16);

    // Perf counters: 10 pulses, 3 mispredicts, plus mispred without valid.
    for (int i = 0; i < 10; i++) step(1'b1, 6'(i), 1'b0, (i % 4 == 1), 32'h100);
    step(1'b0, 6'd0, 1'b0, 1'b1, 32'h100);
    step(1'b0, 6'd0, 1'b0, 1'b1, 32'h100);
    look(32'h100);
    chk("perf_br10",  perf_br_b,  32'd10);
    chk("perf_mis3",  perf_mis_b, 32'd3);
    chk("perf_br10a", 32'(perf_br_a), 32'd10);
    for (int i = 0; i < 7; i++) step(1'b1, 6'd1, 1'b1, 1'b0, 32'h100);
    look(32'h100);
    chk("perf_wrap_a", 32'(perf_br_a), 32'd1);
    chk("perf_17_b",   perf_br_b,      32'd17);

    // Randomized traffic against the model, with occasional reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 2) != 0), 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00});
      end
    end
    step(1'b0, 6'd0, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
